// File: rtl/led_pattern_gen.sv
// LED pattern engine: a prescaled tick steps COUNT/SCAN/FILL/BREATHE patterns; a debounced button cycles the mode.
// The leds output is registered one cycle behind the pattern state. tick is a combinational decode of the prescaler.
module led_pattern_gen #(
    parameter int NUM_LEDS        = 8,
    parameter int TICK_DIV        = 12000000,
    parameter int PWM_W           = 8,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic                hwclk,
    input  logic                rst,
    input  logic                mode_btn,
    output logic [NUM_LEDS-1:0] leds,
    output logic [1:0]          mode,
    output logic                tick
);

    localparam int PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int POSW = $clog2(NUM_LEDS);
    localparam int KW   = $clog2(NUM_LEDS + 1);

    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0]   DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [POSW-1:0] POS_MAX   = POSW'(NUM_LEDS - 1);
    localparam logic [KW-1:0]   K_MAX     = KW'(NUM_LEDS);

    typedef enum logic [1:0] {
        M_COUNT   = 2'd0,
        M_SCAN    = 2'd1,
        M_FILL    = 2'd2,
        M_BREATHE = 2'd3
    } mode_t;

    mode_t mode_q, mode_d;

    logic                sync1, sync2, db_lvl;
    logic [DW-1:0]       db_cnt;
    logic                db_hit, mode_evt;

    logic [PW-1:0]       presc;
    logic                tick_raw;

    logic [NUM_LEDS-1:0] cnt;
    logic [POSW-1:0]     scan_pos;
    logic                scan_up;
    logic [KW-1:0]       fill_k;
    logic [PWM_W-1:0]    pwm_cnt, duty;
    logic                duty_up;

    logic [NUM_LEDS-1:0] fill_mask, led_d;

    // The event is the cycle the debounced level is committed to 1, so its side effects land on the same edge.
    assign db_hit   = (sync2 != db_lvl) && (db_cnt == DB_MAX);
    assign mode_evt = db_hit && sync2;
    assign tick_raw = (presc == PRESC_MAX);
    assign tick     = tick_raw && !mode_evt;
    assign mode     = mode_q;

    always_ff @(posedge hwclk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            db_lvl <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= mode_btn;
            sync2 <= sync1;
            if (sync2 == db_lvl) begin
                db_cnt <= '0;
            end else if (db_hit) begin
                db_lvl <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            mode_q <= M_COUNT;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (mode_evt) begin
            mode_d = mode_t'(mode_q + 2'd1);
        end
    end

    // fill_mask = (1<<k)-1 built bitwise so k == NUM_LEDS never overflows.
    always_comb begin
        fill_mask = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            fill_mask[i] = (KW'(i) < fill_k);
        end
    end

    always_comb begin
        led_d = '0;
        case (mode_q)
            M_COUNT:   led_d = cnt;
            M_SCAN:    led_d = NUM_LEDS'(1) << scan_pos;
            M_FILL:    led_d = fill_mask;
            M_BREATHE: led_d = {NUM_LEDS{pwm_cnt < duty}};
            default:   led_d = '0;
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            presc    <= '0;
            cnt      <= '0;
            scan_pos <= '0;
            scan_up  <= 1'b1;
            fill_k   <= '0;
            pwm_cnt  <= '0;
            duty     <= '0;
            duty_up  <= 1'b1;
            leds     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            leds    <= led_d;
            if (mode_evt) begin
                presc    <= '0;
                cnt      <= '0;
                scan_pos <= '0;
                scan_up  <= 1'b1;
                fill_k   <= '0;
                duty     <= '0;
                duty_up  <= 1'b1;
            end else begin
                presc <= tick_raw ? '0 : presc + PW'(1);
                if (tick_raw) begin
                    case (mode_q)
                        M_COUNT: cnt <= cnt + NUM_LEDS'(1);
                        M_SCAN: begin
                            if (scan_up) begin
                                if (scan_pos == POS_MAX) begin
                                    scan_up  <= 1'b0;
                                    scan_pos <= scan_pos - POSW'(1);
                                end else begin
                                    scan_pos <= scan_pos + POSW'(1);
                                end
                            end else begin
                                if (scan_pos == '0) begin
                                    scan_up  <= 1'b1;
                                    scan_pos <= scan_pos + POSW'(1);
                                end else begin
                                    scan_pos <= scan_pos - POSW'(1);
                                end
                            end
                        end
                        M_FILL: fill_k <= (fill_k == K_MAX) ? '0 : fill_k + KW'(1);
                        M_BREATHE: begin
                            if (duty_up) begin
                                if (duty == '1) begin
                                    duty_up <= 1'b0;
                                    duty    <= duty - PWM_W'(1);
                                end else begin
                                    duty <= duty + PWM_W'(1);
                                end
                            end else begin
                                if (duty == '0) begin
                                    duty_up <= 1'b1;
                                    duty    <= duty + PWM_W'(1);
                                end else begin
                                    duty <= duty - PWM_W'(1);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
